dl_checker: RTL and testbench
=============================

DL_CHECKER -- requirements
Module: dl_checker

Interface
REQ-001 SETTLE, 3: cycles (1..15) Q/Qb may lag the expected value after an expected-value change or an E rise.
REQ-002 CNT_W, 16: width of sample and error counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  checking enable; low forces IDLE.
REQ-006 clr  in  1  synchronous clear of counters and sticky flags; state machine unaffected.
REQ-007 d, e  in  1 each  latch data and enable, as driven to the DUT; asynchronous to clk.
REQ-008 q, qb  in  1 each  DUT outputs; asynchronous to clk.
REQ-009 err  out  1  one-cycle pulse for each failing compare.
REQ-010 err_seen  out  1  sticky flag; set on first failure.
REQ-011 busy  out  1  high in INIT, CHECK and SETTLE.
REQ-012 sample_cnt  out  CNT_W  number of CHECK-state compares; saturates at all-ones.
REQ-013 err_cnt  out  CNT_W  number of failing compares; saturates at all-ones.
REQ-014 first_err  out  CNT_W  sample_cnt value at the first failure; holds until clr or reset.

Function
REQ-015 d, e, q and qb SHALL each pass through a 2-flop synchronizer; all logic uses the synchronized values d_s, e_s, q_s, qb_s.
REQ-016 An expected-value register exp SHALL load d_s on every cycle where e_s=1 and hold otherwise, in every state except IDLE.
REQ-017 States: IDLE, INIT, CHECK, SETTLE; a settle counter scnt counts down from SETTLE.
REQ-018 IDLE -> INIT when en=1; scnt loads SETTLE.
REQ-019 INIT: decrement scnt each cycle; at scnt=0, load exp from q_s (or d_s if e_s=1), then go to CHECK.
REQ-020 CHECK: one compare per cycle; pass iff q_s==exp and qb_s==~exp; sample_cnt increments on every compare.
REQ-021 On a failing compare: err=1 for that cycle, err_cnt increments, err_seen sets; if err_seen was 0, first_err loads the pre-increment sample_cnt.
REQ-022 CHECK -> SETTLE with scnt=SETTLE when the next exp differs from the current exp or e_s rises; the compare in that cycle is suppressed and sample_cnt does not change.
REQ-023 SETTLE: no compares; decrement scnt; a further exp change or e_s rise reloads scnt=SETTLE; -> CHECK when scnt reaches 0.
REQ-024 q_s==qb_s in CHECK SHALL fail regardless of exp.
REQ-025 en=0 in any state -> IDLE next cycle; counters and flags hold; err=0.
REQ-026 clr=1 zeroes sample_cnt, err_cnt, first_err and err_seen; clr has priority over same-cycle increments.
REQ-027 Saturated counters hold at all-ones; a failing compare at saturation still pulses err.
REQ-028 Latency: a DUT output fault reaches err 3 cycles after its clk-aligned appearance on q (2 sync + 1 compare register).

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, err=0, err_seen=0, busy=0, all counters=0, exp=0, scnt=0 and synchronizer flops=0.
REQ-030 Reset deassertion mid-operation SHALL restart from IDLE; no partial state survives.

Verification
REQ-031 Correct latch model, en=1, e=1, d toggling every 10 cycles for 200 cycles -> err never pulses, err_cnt=0, sample_cnt>0.
REQ-032 q stuck at 0, e=1, d=1 held -> err pulses every CHECK cycle after INIT; first_err=0; err_seen=1.
REQ-033 e=0, d toggled every 5 cycles, q/qb held -> zero errors (hold behaviour), sample_cnt increments every cycle.
REQ-034 q follows d 2 cycles late with SETTLE=3 -> zero errors; repeat with a 5-cycle lag -> err_cnt>0.
REQ-035 q=qb=1 forced in CHECK -> err pulses; clr for 1 cycle -> err_cnt=0, err_seen=0, and err_cnt increments again on the next failing compare.
REQ-036 CNT_W=4, persistent fault for 20 compares -> err_cnt=15; rst_n low mid-run -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/dl_checker.sv
// rtl/dl_checker.sv - latch output checker with settle window and saturating error statistics
module dl_checker #(
    parameter int SETTLE = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    input  logic             e,
    input  logic             q,
    input  logic             qb,
    output logic             err,
    output logic             err_seen,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_CHECK, ST_SETTLE} state_t;

    localparam logic [3:0] SETTLE_V = SETTLE[3:0];

    state_t     state, state_nx;
    logic [3:0] scnt, scnt_nx;
    logic       exp_q, exp_nx;
    logic       e_prev;
    logic [1:0] d_sy, e_sy, q_sy, qb_sy;
    logic       d_s, e_s, q_s, qb_s;
    logic       exp_follow, e_rise, change;
    logic       do_cmp, cmp_fail;

    assign d_s  = d_sy[1];
    assign e_s  = e_sy[1];
    assign q_s  = q_sy[1];
    assign qb_s = qb_sy[1];
    assign busy = (state != ST_IDLE);

    // Two-flop synchronizers for the asynchronous latch pins, plus e_s history for rise detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_sy   <= '0;
            e_sy   <= '0;
            q_sy   <= '0;
            qb_sy  <= '0;
            e_prev <= 1'b0;
        end else begin
            d_sy   <= {d_sy[0], d};
            e_sy   <= {e_sy[0], e};
            q_sy   <= {q_sy[0], q};
            qb_sy  <= {qb_sy[0], qb};
            e_prev <= e_s;
        end
    end

    // Next state, settle counter and expected value; a change of expectation suppresses the compare
    always_comb begin
        state_nx   = state;
        scnt_nx    = scnt;
        exp_nx     = exp_q;
        do_cmp     = 1'b0;
        exp_follow = e_s ? d_s : exp_q;
        e_rise     = e_s & ~e_prev;
        change     = (exp_follow != exp_q) | e_rise;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nx = ST_INIT;
                    scnt_nx  = SETTLE_V;
                end
            end
            ST_INIT: begin
                exp_nx = exp_follow;
                if (scnt == 4'd0) begin
                    exp_nx   = e_s ? d_s : q_s;
                    state_nx = ST_CHECK;
                end else begin
                    scnt_nx = scnt - 4'd1;
                end
            end
            ST_CHECK: begin
                exp_nx = exp_follow;
                if (change) begin
                    state_nx = ST_SETTLE;
                    scnt_nx  = SETTLE_V;
                end else begin
                    do_cmp = 1'b1;
                end
            end
            ST_SETTLE: begin
                exp_nx = exp_follow;
                if (change) begin
                    scnt_nx = SETTLE_V;
                end else if (scnt <= 4'd1) begin
                    scnt_nx  = 4'd0;
                    state_nx = ST_CHECK;
                end else begin
                    scnt_nx = scnt - 4'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (!en) begin
            state_nx = ST_IDLE;
            do_cmp   = 1'b0;
        end
        // q_s == qb_s can never satisfy both terms, so it always fails
        cmp_fail = do_cmp & ~((q_s == exp_q) & (qb_s == ~exp_q));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            scnt  <= 4'd0;
            exp_q <= 1'b0;
        end else begin
            state <= state_nx;
            scnt  <= scnt_nx;
            exp_q <= exp_nx;
        end
    end

    // Error pulse and saturating statistics; clr wins over same-cycle increments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err        <= 1'b0;
            err_seen   <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            first_err  <= '0;
        end else begin
            err <= cmp_fail;
            if (clr) begin
                err_seen   <= 1'b0;
                sample_cnt <= '0;
                err_cnt    <= '0;
                first_err  <= '0;
            end else if (do_cmp) begin
                if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
                if (cmp_fail) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                    err_seen <= 1'b1;
                    if (!err_seen) first_err <= sample_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_dl_checker.sv
// tb/tb_dl_checker.sv - table-driven self-checking bench for dl_checker
module tb_dl_checker;

    logic clk, rst_n, en, clr, d, e, q, qb;
    logic        err, err_seen, busy;
    logic [15:0] sample_cnt, err_cnt, first_err;
    logic        err4, err_seen4, busy4;
    logic [3:0]  sample_cnt4, err_cnt4, first_err4;

    int total = 0;
    int bad   = 0;

    dl_checker #(.SETTLE(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .e(e), .q(q), .qb(qb),
        .err(err), .err_seen(err_seen), .busy(busy),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .first_err(first_err)
    );

    dl_checker #(.SETTLE(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .e(e), .q(q), .qb(qb),
        .err(err4), .err_seen(err_seen4), .busy(busy4),
        .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .first_err(first_err4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic e_v;
        logic d0;
        int   period;
        logic follow;
        int   lag;
        logic qv;
        logic qbv;
        int   ncyc;
        int   x_samp;
        int   x_errs;
        logic x_seen;
        int   x_first;
        logic x_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Reset, hold inputs steady, then enable and run the vector for ncyc edges
    task automatic run_vec(input int idx, input vec_t v);
        logic dh[0:255];
        logic dcur, qq;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        e = v.e_v; d = v.d0;
        q  = v.follow ? v.d0  : v.qv;
        qb = v.follow ? ~v.d0 : v.qbv;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        dcur = v.d0;
        for (int i = 0; i < v.ncyc; i++) begin
            if (i > 0) @(negedge clk);
            en = 1'b1;
            if (v.period > 0 && i > 0 && (i % v.period) == 0) dcur = ~dcur;
            dh[i] = dcur;
            d = dcur;
            if (v.follow) begin
                qq = (i >= v.lag) ? dh[i - v.lag] : v.d0;
                q  = qq;
                qb = ~qq;
            end
        end
        @(negedge clk);
        chk({tag, "_sample_cnt"}, sample_cnt, v.x_samp);
        chk({tag, "_err_cnt"},    err_cnt,    v.x_errs);
        chk({tag, "_err_seen"},   err_seen,   v.x_seen);
        chk({tag, "_first_err"},  first_err,  v.x_first);
        chk({tag, "_err"},        err,        v.x_err);
        chk({tag, "_busy"},       busy,       1);
        en = 1'b0;
    endtask

    task automatic setup_steady(input logic dv, input logic qv, input logic qbv);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        e = 1'b1; d = dv; q = qv; qb = qbv;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; clr = 1'b0;
        d = 1'b0; e = 1'b0; q = 1'b0; qb = 1'b1;

        //          e     d0    per follow lag qv    qbv   ncyc samp errs seen  first err
        vecs[0] = '{1'b1, 1'b0, 10, 1'b1, 0, 1'b0, 1'b0, 200, 119, 0,  1'b0, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 0,  1'b0, 0, 1'b0, 1'b1, 20,  15,  15, 1'b1, 0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 5,  1'b0, 0, 1'b1, 1'b0, 40,  35,  0,  1'b0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 10, 1'b1, 2, 1'b0, 1'b0, 100, 59,  0,  1'b0, 0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 10, 1'b1, 4, 1'b0, 1'b0, 100, 59,  0,  1'b0, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 10, 1'b1, 5, 1'b0, 1'b0, 100, 59,  9,  1'b1, 7, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 0,  1'b0, 0, 1'b1, 1'b1, 12,  7,   7,  1'b1, 0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0, 12,  7,   7,  1'b1, 0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 0,  1'b0, 0, 1'b1, 1'b0, 12,  7,   0,  1'b0, 0, 1'b0};

        // Asynchronous reset takes effect without a clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_err",        err,        0);
        chk("rst_err_seen",   err_seen,   0);
        chk("rst_busy",       busy,       0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_err_cnt",    err_cnt,    0);
        chk("rst_first_err",  first_err,  0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Persistent fault: 20 compares, narrow counters saturate
        setup_steady(1'b1, 1'b0, 1'b1);
        en = 1'b1;
        repeat (25) @(negedge clk);
        chk("sat_err_cnt4",    err_cnt4,    15);
        chk("sat_sample_cnt4", sample_cnt4, 15);
        chk("sat_err4",        err4,        1);
        chk("sat_first_err4",  first_err4,  0);
        chk("wide_err_cnt",    err_cnt,     20);

        // Clear beats the same-cycle failing compare, then counting resumes
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_err_cnt",    err_cnt,    0);
        chk("clr_err_seen",   err_seen,   0);
        chk("clr_sample_cnt", sample_cnt, 0);
        chk("clr_first_err",  first_err,  0);
        chk("clr_busy",       busy,       1);
        @(negedge clk);
        chk("post_clr_err_cnt",    err_cnt,    1);
        chk("post_clr_err_seen",   err_seen,   1);
        chk("post_clr_sample_cnt", sample_cnt, 1);
        chk("post_clr_first_err",  first_err,  0);
        chk("post_clr_err_cnt4",   err_cnt4,   1);

        // Dropping en returns to IDLE with counters held
        en = 1'b0;
        @(negedge clk);
        chk("dis_busy",    busy,    0);
        chk("dis_err",     err,     0);
        chk("dis_err_cnt", err_cnt, 1);

        // Re-enable, then reset mid-cycle
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("reen_err_cnt", err_cnt, 6);
        chk("reen_err",     err,     1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_err",        err,        0);
        chk("mid_rst_busy",       busy,       0);
        chk("mid_rst_err_seen",   err_seen,   0);
        chk("mid_rst_err_cnt",    err_cnt,    0);
        chk("mid_rst_sample_cnt", sample_cnt, 0);
        chk("mid_rst_err_cnt4",   err_cnt4,   0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("restart_busy",    busy,    1);
        chk("restart_err_cnt", err_cnt, 0);
        @(negedge clk);
        chk("restart_first_cmp", err_cnt, 1);

        // Fault on q reaches err on the third edge
        setup_steady(1'b1, 1'b1, 1'b0);
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("lat_clean", err_cnt, 0);
        q = 1'b0; qb = 1'b0;
        @(negedge clk);
        chk("lat_edge1", err, 0);
        @(negedge clk);
        chk("lat_edge2", err, 0);
        @(negedge clk);
        chk("lat_edge3", err, 1);
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
